// File: rtl/ahb5_to_apb4_bridge.sv
// AHB5 slave to APB4 master bridge.
// Each accepted single AHB transfer is registered and then replayed on APB as a SETUP/ACCESS
// pair. The AHB data phase is stretched (HREADYOUT low) until the APB access completes.
// APB errors and illegal transfers return a two-cycle AHB ERROR response.
//
// Ports:
//   HCLK, HRESETn            clock, asynchronous active-low reset
//   HSEL..HREADY             AHB5 slave address/data-phase inputs
//   HREADYOUT, HRESP, HRDATA AHB5 slave response
//   PADDR..PPROT             APB4 master request (all registered)
//   PREADY, PSLVERR, PRDATA  APB4 completion inputs
module ahb5_to_apb4_bridge #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [3:0]        HPROT,
  input  logic              HNONSEC,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [31:0]       PWDATA,
  output logic [3:0]        PSTRB,
  output logic [2:0]        PPROT,
  input  logic              PREADY,
  input  logic              PSLVERR,
  input  logic [31:0]       PRDATA
);

  typedef enum logic [2:0] {
    StIdle,
    StWdata,
    StSetup,
    StAccess,
    StErr1,
    StErr2
  } state_e;

  state_e     r_state;
  state_e     w_state_d;
  logic       w_accept;
  logic       w_illegal;
  logic [3:0] w_strb;
  logic       w_unused;

  // HPROT[3:2] (cacheable/bufferable) have no APB4 equivalent.
  assign w_unused = ^HPROT[3:2];

  // New transfers are only sampled in the two states that present HREADYOUT=1.
  assign w_accept = HSEL && HREADY && (HTRANS == 2'b10 || HTRANS == 2'b11) &&
                    (r_state == StIdle || r_state == StErr2);

  // Sizes above a word, or addresses not aligned to the size, are rejected.
  always_comb begin
    case (HSIZE)
      3'd0:    w_illegal = 1'b0;
      3'd1:    w_illegal = HADDR[0];
      3'd2:    w_illegal = |HADDR[1:0];
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_strb = 4'b0000;
    if (HWRITE) begin
      case (HSIZE)
        3'd0:    w_strb = 4'b0001 << HADDR[1:0];
        3'd1:    w_strb = 4'b0011 << {HADDR[1], 1'b0};
        default: w_strb = 4'b1111;
      endcase
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle, StErr2: begin
        if (!w_accept)     w_state_d = StIdle;
        else if (w_illegal) w_state_d = StErr1;
        else if (HWRITE)   w_state_d = StWdata;
        else               w_state_d = StSetup;
      end
      StWdata:  w_state_d = StSetup;
      StSetup:  w_state_d = StAccess;
      StAccess: if (PREADY) w_state_d = PSLVERR ? StErr1 : StIdle;
      StErr1:   w_state_d = StErr2;
      default:  w_state_d = StIdle;
    endcase
  end

  // Handshake outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state   <= StIdle;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= '0;
      PADDR     <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      PPROT     <= '0;
    end else begin
      r_state   <= w_state_d;
      HREADYOUT <= (w_state_d == StIdle) || (w_state_d == StErr2);
      HRESP     <= (w_state_d == StErr1) || (w_state_d == StErr2);
      PSEL      <= (w_state_d == StSetup) || (w_state_d == StAccess);
      PENABLE   <= (w_state_d == StAccess);
      // Illegal transfers never reach APB, so the APB request keeps its previous value.
      if (w_accept && !w_illegal) begin
        PADDR  <= HADDR;
        PWRITE <= HWRITE;
        PSTRB  <= w_strb;
        PPROT  <= {~HPROT[0], HNONSEC, HPROT[1]};
      end
      if (r_state == StWdata) begin
        PWDATA <= HWDATA;
      end
      if (r_state == StAccess && PREADY && !PSLVERR && !PWRITE) begin
        HRDATA <= PRDATA;
      end
    end
  end

endmodule

// File: tb/tb_ahb5_to_apb4_bridge.sv
// Self-checking bench for ahb5_to_apb4_bridge: a transaction-level model schedules the
// expected AHB/APB handshake for each cycle; one process compares the DUT every cycle.
module tb_ahb5_to_apb4_bridge;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = '0;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = '0;
  logic [3:0]  HPROT = '0;
  logic        HNONSEC = 1'b0;
  logic [31:0] HWDATA = '0;
  logic        HREADY = 1'b1;
  logic        HREADYOUT, HRESP;
  logic [31:0] HRDATA;
  logic [31:0] PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;
  logic [31:0] PRDATA = '0;

  ahb5_to_apb4_bridge #(.ADDR_W(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT), .HNONSEC(HNONSEC), .HWDATA(HWDATA),
    .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PPROT(PPROT), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  always #5 HCLK = ~HCLK;

  int unsigned cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  // Model state: expected outputs for the current cycle.
  logic        exp_ready = 1'b1, exp_resp = 1'b0, exp_psel = 1'b0, exp_pen = 1'b0;
  logic [31:0] exp_hrdata = '0;
  logic [31:0] exp_paddr = '0, exp_pwdata = '0;
  logic        exp_pwrite = 1'b0;
  logic [3:0]  exp_pstrb = '0;
  logic [2:0]  exp_pprot = '0;
  logic        cur_resp = 1'b0;
  logic        hr_pend = 1'b0;
  logic [31:0] hr_val = '0;
  logic        chk_en = 1'b0;
  int unsigned a_cyc = 0;

  // Observations used by the literal checks.
  int unsigned seen_setup_cyc = 0, seen_acc_cyc = 0;
  logic [31:0] seen_paddr = '0, seen_pwdata = '0;
  logic [3:0]  seen_pstrb = '0;
  logic        seen_pwrite = 1'b0;
  logic        prev_pen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge HCLK) begin
    if (chk_en) begin
      chk("HREADYOUT", 32'(HREADYOUT), 32'(exp_ready));
      chk("HRESP", 32'(HRESP), 32'(exp_resp));
      chk("PSEL", 32'(PSEL), 32'(exp_psel));
      chk("PENABLE", 32'(PENABLE), 32'(exp_pen));
      chk("HRDATA", HRDATA, exp_hrdata);
      if (exp_psel) begin
        chk("PADDR", PADDR, exp_paddr);
        chk("PWRITE", 32'(PWRITE), 32'(exp_pwrite));
        chk("PSTRB", 32'(PSTRB), 32'(exp_pstrb));
        chk("PPROT", 32'(PPROT), 32'(exp_pprot));
        if (exp_pwrite) chk("PWDATA", PWDATA, exp_pwdata);
      end
    end
    if (PSEL && !PENABLE) begin
      seen_setup_cyc = cyc;
      seen_paddr = PADDR;
      seen_pwdata = PWDATA;
      seen_pstrb = PSTRB;
      seen_pwrite = PWRITE;
    end
    if (PENABLE && !prev_pen) seen_acc_cyc = cyc;
    prev_pen = PENABLE;
  end

  task automatic set_exp(input logic r, input logic resp, input logic ps, input logic pe);
    exp_ready = r; exp_resp = resp; exp_psel = ps; exp_pen = pe;
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
    if (hr_pend) begin exp_hrdata = hr_val; hr_pend = 1'b0; end
  endtask

  // Inputs during a stretched data phase: bus HREADY is low, everything else is noise.
  task automatic quiet();
    HSEL = 1'($urandom); HTRANS = 2'($urandom); HREADY = 1'b0; HADDR = $urandom;
    HWRITE = 1'($urandom); HSIZE = 3'($urandom); HWDATA = $urandom;
    PREADY = 1'b0; PSLVERR = 1'($urandom); PRDATA = $urandom;
  endtask

  // One cycle in which the slave presents HREADYOUT=1 and the master drives an address phase.
  task automatic addr_cycle(input logic sel, input logic [1:0] trans, input logic rdy,
                            input logic [31:0] addr, input logic wr, input logic [2:0] size,
                            input logic [3:0] prot, input logic ns,
                            output logic acc, output logic ill);
    int unsigned nb;
    step();
    HSEL = sel; HTRANS = trans; HREADY = rdy; HADDR = addr; HWRITE = wr; HSIZE = size;
    HPROT = prot; HNONSEC = ns; HWDATA = $urandom;
    PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
    set_exp(1'b1, cur_resp, 1'b0, 1'b0);
    a_cyc = cyc;
    acc = sel && rdy && trans[1];
    ill = (size > 3'd2) || ((addr % (32'd1 << size)) != 0);
    cur_resp = 1'b0;
    if (acc && !ill) begin
      exp_paddr = addr;
      exp_pwrite = wr;
      exp_pprot = {~prot[0], ns, prot[1]};
      nb = 32'd1 << size;
      for (int i = 0; i < 4; i++)
        exp_pstrb[i] = wr && (i >= int'(addr[1:0])) && (i < int'(addr[1:0]) + int'(nb));
    end
  endtask

  task automatic data_cycles(input logic wr, input logic ill, input int waits, input logic err,
                             input logic [31:0] wdata, input logic [31:0] rdata);
    if (ill) begin
      step(); quiet(); set_exp(1'b0, 1'b1, 1'b0, 1'b0); cur_resp = 1'b1;
      return;
    end
    if (wr) begin
      step(); quiet(); HWDATA = wdata; set_exp(1'b0, 1'b0, 1'b0, 1'b0); exp_pwdata = wdata;
    end
    step(); quiet(); set_exp(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i <= waits; i++) begin
      step(); quiet(); set_exp(1'b0, 1'b0, 1'b1, 1'b1);
      if (i == waits) begin PREADY = 1'b1; PSLVERR = err; PRDATA = rdata; end
    end
    if (err) begin
      step(); quiet(); set_exp(1'b0, 1'b1, 1'b0, 1'b0); cur_resp = 1'b1;
    end else if (!wr) begin
      hr_pend = 1'b1; hr_val = rdata;
    end
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input int waits, input logic err, input logic [31:0] wdata,
                      input logic [31:0] rdata);
    logic acc, ill;
    addr_cycle(1'b1, 2'b10, 1'b1, addr, wr, size, 4'($urandom), 1'($urandom), acc, ill);
    data_cycles(wr, ill, waits, err, wdata, rdata);
  endtask

  task automatic idle_cycle(input logic sel, input logic [1:0] trans, input logic rdy);
    logic acc, ill;
    addr_cycle(sel, trans, rdy, $urandom, 1'($urandom), 3'd2, 4'($urandom), 1'($urandom),
               acc, ill);
  endtask

  int unsigned a0;
  logic        s, r;
  logic [1:0]  t;
  logic [2:0]  sz;
  logic [31:0] addr;
  int          k;

  initial begin
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst HREADYOUT", 32'(HREADYOUT), 32'd1);
    chk("rst HRESP", 32'(HRESP), 32'd0);
    chk("rst HRDATA", HRDATA, 32'd0);
    chk("rst PADDR", PADDR, 32'd0);
    chk("rst PSEL", 32'(PSEL), 32'd0);
    chk("rst PENABLE", 32'(PENABLE), 32'd0);
    chk("rst PWRITE", 32'(PWRITE), 32'd0);
    chk("rst PWDATA", PWDATA, 32'd0);
    chk("rst PSTRB", 32'(PSTRB), 32'd0);
    chk("rst PPROT", 32'(PPROT), 32'd0);
    HRESETn = 1'b1;
    HSEL = 1'b0; HTRANS = 2'b00; HREADY = 1'b1;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;

    // Word write with zero wait states.
    xfer(1'b1, 32'h4000_0010, 3'd2, 0, 1'b0, 32'hDEAD_BEEF, 32'h0);
    a0 = a_cyc;
    idle_cycle(1'b0, 2'b00, 1'b1);
    chk("lit wr setup at A+2", seen_setup_cyc - a0, 32'd2);
    chk("lit wr access at A+3", seen_acc_cyc - a0, 32'd3);
    chk("lit wr ready at A+4", cyc - a0, 32'd4);
    chk("lit wr HREADYOUT", 32'(HREADYOUT), 32'd1);
    chk("lit wr HRESP", 32'(HRESP), 32'd0);
    chk("lit wr PADDR", seen_paddr, 32'h4000_0010);
    chk("lit wr PWDATA", seen_pwdata, 32'hDEAD_BEEF);
    chk("lit wr PSTRB", 32'(seen_pstrb), 32'hF);
    chk("lit wr PWRITE", 32'(seen_pwrite), 32'd1);

    // Byte, halfword strobes and a word read, back to back.
    xfer(1'b1, 32'h4000_0003, 3'd0, 0, 1'b0, 32'h1111_2222, 32'h0);
    chk("lit byte PSTRB", 32'(seen_pstrb), 32'b1000);
    xfer(1'b1, 32'h4000_0002, 3'd1, 1, 1'b0, 32'h3333_4444, 32'h0);
    chk("lit half PSTRB", 32'(seen_pstrb), 32'b1100);
    xfer(1'b0, 32'h4000_0008, 3'd2, 0, 1'b0, 32'h0, 32'hA5A5_5A5A);
    chk("lit read PSTRB", 32'(seen_pstrb), 32'b0000);

    // Read with three PREADY-low cycles.
    xfer(1'b0, 32'h0000_0100, 3'd2, 3, 1'b0, 32'h0, 32'h1234_5678);
    a0 = a_cyc;
    idle_cycle(1'b0, 2'b00, 1'b1);
    chk("lit rd ready at A+6", cyc - a0, 32'd6);
    chk("lit rd HRDATA", HRDATA, 32'h1234_5678);
    chk("lit rd HREADYOUT", 32'(HREADYOUT), 32'd1);

    // APB slave error, then illegal transfers.
    xfer(1'b0, 32'h0000_0104, 3'd2, 0, 1'b1, 32'h0, 32'hFFFF_0000);
    chk("lit err1 HREADYOUT", 32'(HREADYOUT), 32'd0);
    chk("lit err1 HRESP", 32'(HRESP), 32'd1);
    idle_cycle(1'b0, 2'b00, 1'b1);
    chk("lit err2 HREADYOUT", 32'(HREADYOUT), 32'd1);
    chk("lit err2 HRESP", 32'(HRESP), 32'd1);
    idle_cycle(1'b0, 2'b00, 1'b1);
    chk("lit okay HRESP", 32'(HRESP), 32'd0);
    xfer(1'b1, 32'h0000_0000, 3'd3, 0, 1'b0, 32'h0, 32'h0);
    chk("lit size3 HRESP", 32'(HRESP), 32'd1);
    xfer(1'b0, 32'h0000_0002, 3'd2, 0, 1'b0, 32'h0, 32'h0);
    chk("lit misalign HRESP", 32'(HRESP), 32'd1);

    // Read then write with no gap; non-accepting address phases.
    xfer(1'b0, 32'h0000_0200, 3'd2, 0, 1'b0, 32'h0, 32'h0BAD_F00D);
    xfer(1'b1, 32'h0000_0204, 3'd2, 0, 1'b0, 32'h7777_8888, 32'h0);
    idle_cycle(1'b1, 2'b00, 1'b1);
    idle_cycle(1'b1, 2'b01, 1'b1);
    idle_cycle(1'b1, 2'b10, 1'b0);
    chk("lit ignored PSEL", 32'(PSEL), 32'd0);

    // Reset asserted during ACCESS of a word write.
    begin
      logic acc, ill;
      addr_cycle(1'b1, 2'b10, 1'b1, 32'h0000_0300, 1'b1, 3'd2, 4'h3, 1'b1, acc, ill);
    end
    step(); quiet(); HWDATA = 32'hCAFE_F00D; set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    exp_pwdata = 32'hCAFE_F00D;
    step(); quiet(); set_exp(1'b0, 1'b0, 1'b1, 1'b0);
    step(); quiet(); set_exp(1'b0, 1'b0, 1'b1, 1'b1);
    #2;
    chk_en = 1'b0;
    HRESETn = 1'b0;
    #1;
    chk("rstmid PSEL", 32'(PSEL), 32'd0);
    chk("rstmid PENABLE", 32'(PENABLE), 32'd0);
    chk("rstmid PSTRB", 32'(PSTRB), 32'd0);
    chk("rstmid HREADYOUT", 32'(HREADYOUT), 32'd1);
    chk("rstmid PWDATA", PWDATA, 32'd0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    HSEL = 1'b0; HTRANS = 2'b00; HREADY = 1'b1;
    cur_resp = 1'b0; exp_hrdata = '0; hr_pend = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    xfer(1'b0, 32'h0000_0400, 3'd2, 1, 1'b0, 32'h0, 32'h5555_AAAA);
    xfer(1'b1, 32'h0000_0401, 3'd0, 0, 1'b0, 32'h0102_0304, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 9);
      if (k < 2) begin
        s = 1'($urandom); t = 2'($urandom); r = 1'($urandom);
        if (s && r && t[1]) t[1] = 1'b0;
        idle_cycle(s, t, r);
      end else begin
        sz = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        addr = $urandom;
        if ($urandom_range(0, 9) != 0 && sz <= 3'd2) addr = addr & ~((32'd1 << sz) - 32'd1);
        xfer(1'($urandom), addr, sz, $urandom_range(0, 3), ($urandom_range(0, 6) == 0),
             $urandom, $urandom);
      end
    end
    idle_cycle(1'b0, 2'b00, 1'b1);
    idle_cycle(1'b0, 2'b00, 1'b1);
    @(posedge HCLK);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
